// File: rtl/alu_pkg.sv
// Shared definitions for the execute-stage ALU.
//   - Major opcode values the ALU recognises.
//   - ALU function codes used by register and immediate ALU opcodes.
//   - Bit positions inside the {O,S,Z,C} flag register.
//   - Barrel-shifter operation kinds.
package alu_pkg;

  localparam logic [4:0] OP_ALU_R  = 5'd0;
  localparam logic [4:0] OP_ALU_I  = 5'd1;
  localparam logic [4:0] OP_LUI    = 5'd2;
  localparam logic [4:0] OP_MEM_LO = 5'd3;
  localparam logic [4:0] OP_MEM_HI = 5'd11;
  localparam logic [4:0] OP_ADPC   = 5'd22;

  localparam logic [4:0] AOP_AND  = 5'd0;
  localparam logic [4:0] AOP_NAND = 5'd1;
  localparam logic [4:0] AOP_OR   = 5'd2;
  localparam logic [4:0] AOP_NOR  = 5'd3;
  localparam logic [4:0] AOP_XOR  = 5'd4;
  localparam logic [4:0] AOP_XNOR = 5'd5;
  localparam logic [4:0] AOP_NOT  = 5'd6;
  localparam logic [4:0] AOP_LSL  = 5'd7;
  localparam logic [4:0] AOP_LSR  = 5'd8;
  localparam logic [4:0] AOP_ASR  = 5'd9;
  localparam logic [4:0] AOP_ROTL = 5'd10;
  localparam logic [4:0] AOP_ROTR = 5'd11;
  localparam logic [4:0] AOP_ADD  = 5'd14;
  localparam logic [4:0] AOP_ADDC = 5'd15;
  localparam logic [4:0] AOP_SUB  = 5'd16;
  localparam logic [4:0] AOP_SUBB = 5'd17;
  localparam logic [4:0] AOP_MUL  = 5'd18;

  localparam int unsigned FLAG_C = 0;
  localparam int unsigned FLAG_Z = 1;
  localparam int unsigned FLAG_S = 2;
  localparam int unsigned FLAG_O = 3;

  typedef enum logic [2:0] {
    SH_LSL = 3'd0,
    SH_LSR = 3'd1,
    SH_ASR = 3'd2,
    SH_ROL = 3'd3,
    SH_ROR = 3'd4
  } shift_kind_e;

  function automatic logic is_flag_op(input logic [4:0] opcode);
    return (opcode == OP_ALU_R) || (opcode == OP_ALU_I);
  endfunction

endpackage

// File: rtl/alu_shifter.sv
// 32-bit barrel shifter for lsl/lsr/asr/rotl/rotr.
//   kind   : shift_kind_e encoding of the operation
//   value  : operand to shift
//   amt    : shift amount 0..31
//   result : shifted value
//   carry  : last bit shifted out (0 when amt is 0)
module alu_shifter
  import alu_pkg::*;
(
  input  logic [2:0]  kind,
  input  logic [31:0] value,
  input  logic [4:0]  amt,
  output logic [31:0] result,
  output logic        carry
);

  shift_kind_e k;
  logic [4:0]  amt_m1;   // index of last bit leaving on a right shift
  logic [4:0]  amt_inv;  // 32-amt mod 32: index of last bit leaving on a left shift

  assign k       = shift_kind_e'(kind);
  assign amt_m1  = amt - 5'd1;
  assign amt_inv = 5'd0 - amt;

  always_comb begin
    result = value;
    carry  = 1'b0;
    unique case (k)
      SH_LSL: begin
        result = value << amt;
        carry  = value[amt_inv];
      end
      SH_LSR: begin
        result = value >> amt;
        carry  = value[amt_m1];
      end
      SH_ASR: begin
        result = $signed(value) >>> amt;
        carry  = value[amt_m1];
      end
      SH_ROL: begin
        // amt==0 gives amt_inv==0, so both halves equal value and the OR is a no-op
        result = (value << amt) | (value >> amt_inv);
        carry  = value[amt_inv];
      end
      SH_ROR: begin
        result = (value >> amt) | (value << amt_inv);
        carry  = value[amt_m1];
      end
      default: begin
        result = value;
        carry  = 1'b0;
      end
    endcase
    if (amt == 5'd0) carry = 1'b0;
  end

endmodule

// File: rtl/alu.sv
// Execute-stage ALU: combinational 32-bit result plus a registered
// {O,S,Z,C} condition-flag file for the branch-condition decoder.
//   clk, rst_n : pipeline clock, synchronous active-low reset
//   opcode     : instruction major opcode
//   alu_op     : ALU function code for opcodes 0/1
//   lhs, rhs   : forwarded operands
//   pc         : PC of the instruction in execute
//   bubble     : empty slot, suppresses flag update
//   result     : combinational result
//   flags      : registered {O,S,Z,C}
module alu
  import alu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  opcode,
  input  logic [4:0]  alu_op,
  input  logic [31:0] lhs,
  input  logic [31:0] rhs,
  input  logic [31:0] pc,
  input  logic        bubble,
  output logic [31:0] result,
  output logic [3:0]  flags
);

  shift_kind_e sh_kind;
  logic [31:0] sh_res;
  logic        sh_carry;

  logic [31:0] add_b;
  logic        add_cin;
  logic [32:0] sum;
  logic        add_ovf;

  logic [31:0] alu_res;
  logic        alu_c;
  logic        alu_o;
  logic [3:0]  next_flags;

  alu_shifter u_shifter (
    .kind   (sh_kind),
    .value  (lhs),
    .amt    (rhs[4:0]),
    .result (sh_res),
    .carry  (sh_carry)
  );

  always_comb begin
    sh_kind = SH_LSL;
    unique case (alu_op)
      AOP_LSR:  sh_kind = SH_LSR;
      AOP_ASR:  sh_kind = SH_ASR;
      AOP_ROTL: sh_kind = SH_ROL;
      AOP_ROTR: sh_kind = SH_ROR;
      default:  sh_kind = SH_LSL;
    endcase
  end

  // Add and subtract share one adder: subtraction is lhs + ~rhs + cin.
  always_comb begin
    add_b   = rhs;
    add_cin = 1'b0;
    unique case (alu_op)
      AOP_ADDC: add_cin = flags[FLAG_C];
      AOP_SUB: begin
        add_b   = ~rhs;
        add_cin = 1'b1;
      end
      AOP_SUBB: begin
        add_b   = ~rhs;
        add_cin = flags[FLAG_C];
      end
      default: begin
        add_b   = rhs;
        add_cin = 1'b0;
      end
    endcase
    sum     = {1'b0, lhs} + {1'b0, add_b} + {32'd0, add_cin};
    add_ovf = (lhs[31] == add_b[31]) && (sum[31] != lhs[31]);
  end

  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_o   = 1'b0;
    unique case (alu_op)
      AOP_AND:  alu_res = lhs & rhs;
      AOP_NAND: alu_res = ~(lhs & rhs);
      AOP_OR:   alu_res = lhs | rhs;
      AOP_NOR:  alu_res = ~(lhs | rhs);
      AOP_XOR:  alu_res = lhs ^ rhs;
      AOP_XNOR: alu_res = ~(lhs ^ rhs);
      AOP_NOT:  alu_res = ~rhs;
      AOP_LSL, AOP_LSR, AOP_ASR, AOP_ROTL, AOP_ROTR: begin
        alu_res = sh_res;
        alu_c   = sh_carry;
      end
      AOP_ADD, AOP_ADDC, AOP_SUB, AOP_SUBB: begin
        alu_res = sum[31:0];
        alu_c   = sum[32];
        alu_o   = add_ovf;
      end
      AOP_MUL:  alu_res = lhs * rhs;
      default:  alu_res = '0;
    endcase

    next_flags         = '0;
    next_flags[FLAG_Z] = (alu_res == '0);
    next_flags[FLAG_S] = alu_res[31];
    next_flags[FLAG_C] = alu_c;
    next_flags[FLAG_O] = alu_o;
  end

  always_comb begin
    result = '0;
    if (is_flag_op(opcode))
      result = alu_res;
    else if (opcode == OP_LUI)
      result = rhs;
    else if ((opcode >= OP_MEM_LO) && (opcode <= OP_MEM_HI))
      result = lhs + rhs;
    else if (opcode == OP_ADPC)
      result = pc + 32'd4 + rhs;
  end

  always_ff @(posedge clk) begin
    if (!rst_n)
      flags <= '0;
    else if (is_flag_op(opcode) && !bubble)
      flags <= next_flags;
  end

endmodule

// File: tb/tb_alu.sv
module tb_alu;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  opcode;
  logic [4:0]  alu_op;
  logic [31:0] lhs;
  logic [31:0] rhs;
  logic [31:0] pc;
  logic        bubble;
  logic [31:0] result;
  logic [3:0]  flags;

  alu dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .opcode (opcode),
    .alu_op (alu_op),
    .lhs    (lhs),
    .rhs    (rhs),
    .pc     (pc),
    .bubble (bubble),
    .result (result),
    .flags  (flags)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    int unsigned due;
    logic        is_flags;
    logic [31:0] exp;
  } chk_t;

  chk_t        sb[$];
  chk_t        cur;
  int unsigned cyc = 0;
  int          vectors = 0;
  int          miscompares = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: pops every expectation that has come due and compares it
  // against the DUT output, away from the active edge.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      cur = sb.pop_front();
      vectors++;
      if (cur.is_flags) begin
        if (flags !== cur.exp[3:0]) begin
          miscompares++;
          $display("FAIL %s flags: got %b expected %b", cur.name, flags, cur.exp[3:0]);
        end
      end else begin
        if (result !== cur.exp) begin
          miscompares++;
          $display("FAIL %s result: got %h expected %h", cur.name, result, cur.exp);
        end
      end
    end
  end

  // Drive one vector just after a rising edge; its result is due this cycle,
  // its flag effect is visible after the next rising edge.
  task automatic apply(input string nm, input logic rst, input logic [4:0] op,
                       input logic [4:0] aop, input logic [31:0] l, input logic [31:0] r,
                       input logic [31:0] p, input logic bub,
                       input logic [31:0] exp_res, input logic [3:0] exp_fl);
    @(posedge clk);
    #1;
    rst_n  = rst;
    opcode = op;
    alu_op = aop;
    lhs    = l;
    rhs    = r;
    pc     = p;
    bubble = bub;
    sb.push_back('{name: nm, due: cyc,     is_flags: 1'b0, exp: exp_res});
    sb.push_back('{name: nm, due: cyc + 1, is_flags: 1'b1, exp: {28'd0, exp_fl}});
  endtask

  initial begin
    rst_n  = 1'b0;
    opcode = '0;
    alu_op = '0;
    lhs    = '0;
    rhs    = '0;
    pc     = '0;
    bubble = 1'b0;

    //     name          rst   opcode     alu_op    lhs           rhs           pc            bub   result        flags OSZC
    apply("reset",       1'b0, OP_ALU_R,  AOP_ADD,  32'h7FFFFFFF, 32'h00000001, 32'h0,        1'b0, 32'h80000000, 4'b0000);
    apply("add_ovf",     1'b1, OP_ALU_R,  AOP_ADD,  32'h7FFFFFFF, 32'h00000001, 32'h0,        1'b0, 32'h80000000, 4'b1100);
    apply("sub_eq",      1'b1, OP_ALU_R,  AOP_SUB,  32'h5,        32'h5,        32'h0,        1'b0, 32'h00000000, 4'b0011);
    apply("sub_lt",      1'b1, OP_ALU_R,  AOP_SUB,  32'h3,        32'h5,        32'h0,        1'b0, 32'hFFFFFFFE, 4'b0100);
    apply("add_carry",   1'b1, OP_ALU_R,  AOP_ADD,  32'hFFFFFFFF, 32'h1,        32'h0,        1'b0, 32'h00000000, 4'b0011);
    apply("bubble",      1'b1, OP_ALU_R,  AOP_ADD,  32'h0,        32'h0,        32'h0,        1'b1, 32'h00000000, 4'b0011);
    apply("mem_addr",    1'b1, 5'd3,      AOP_SUB,  32'h100,      32'h8,        32'h0,        1'b0, 32'h00000108, 4'b0011);
    apply("addc",        1'b1, OP_ALU_R,  AOP_ADDC, 32'h2,        32'h3,        32'h0,        1'b0, 32'h00000006, 4'b0000);
    apply("lsr",         1'b1, OP_ALU_R,  AOP_LSR,  32'h3,        32'h1,        32'h0,        1'b0, 32'h00000001, 4'b0001);
    apply("asr",         1'b1, OP_ALU_R,  AOP_ASR,  32'h80000000, 32'h4,        32'h0,        1'b0, 32'hF8000000, 4'b0100);
    apply("rotl",        1'b1, OP_ALU_R,  AOP_ROTL, 32'h80000001, 32'h1,        32'h0,        1'b0, 32'h00000003, 4'b0001);
    apply("adpc",        1'b1, OP_ADPC,   AOP_AND,  32'h0,        32'h10,       32'h1000,     1'b0, 32'h00001014, 4'b0001);
    apply("subb_c1",     1'b1, OP_ALU_R,  AOP_SUBB, 32'hA,        32'h3,        32'h0,        1'b0, 32'h00000007, 4'b0001);
    apply("sub_lt2",     1'b1, OP_ALU_R,  AOP_SUB,  32'h3,        32'h5,        32'h0,        1'b0, 32'hFFFFFFFE, 4'b0100);
    apply("subb_c0",     1'b1, OP_ALU_R,  AOP_SUBB, 32'hA,        32'h3,        32'h0,        1'b0, 32'h00000006, 4'b0001);
    apply("sub_ovf",     1'b1, OP_ALU_R,  AOP_SUB,  32'h80000000, 32'h1,        32'h0,        1'b0, 32'h7FFFFFFF, 4'b1001);
    apply("mul",         1'b1, OP_ALU_R,  AOP_MUL,  32'h7,        32'h6,        32'h0,        1'b0, 32'h0000002A, 4'b0000);
    apply("mul_wrap",    1'b1, OP_ALU_R,  AOP_MUL,  32'h10000,    32'h10000,    32'h0,        1'b0, 32'h00000000, 4'b0010);
    apply("lsl",         1'b1, OP_ALU_R,  AOP_LSL,  32'h80000001, 32'h1,        32'h0,        1'b0, 32'h00000002, 4'b0001);
    apply("lsl_zero",    1'b1, OP_ALU_R,  AOP_LSL,  32'h5,        32'h0,        32'h0,        1'b0, 32'h00000005, 4'b0000);
    apply("rotr",        1'b1, OP_ALU_R,  AOP_ROTR, 32'h1,        32'h1,        32'h0,        1'b0, 32'h80000000, 4'b0101);
    apply("nand_imm",    1'b1, OP_ALU_I,  AOP_NAND, 32'hFFFFFFFF, 32'hF0F0F0F0, 32'h0,        1'b0, 32'h0F0F0F0F, 4'b0000);
    apply("xnor",        1'b1, OP_ALU_R,  AOP_XNOR, 32'h12345678, 32'h12345678, 32'h0,        1'b0, 32'hFFFFFFFF, 4'b0100);
    apply("undef_op",    1'b1, OP_ALU_R,  5'd12,    32'h5,        32'h5,        32'h0,        1'b0, 32'h00000000, 4'b0010);
    apply("lui",         1'b1, OP_LUI,    AOP_ADD,  32'h5,        32'hABCD0000, 32'h0,        1'b0, 32'hABCD0000, 4'b0010);
    apply("op_other",    1'b1, 5'd23,     AOP_ADD,  32'h5,        32'h5,        32'h40,       1'b0, 32'h00000000, 4'b0010);
    apply("or_imm",      1'b1, OP_ALU_I,  AOP_OR,   32'h0F,       32'hF0,       32'h0,        1'b0, 32'h000000FF, 4'b0000);
    apply("rotr2",       1'b1, OP_ALU_R,  AOP_ROTR, 32'h1,        32'h1,        32'h0,        1'b0, 32'h80000000, 4'b0101);
    apply("reset_prio",  1'b0, OP_ALU_R,  AOP_ADD,  32'h7FFFFFFF, 32'h1,        32'h0,        1'b0, 32'h80000000, 4'b0000);
    apply("addc_after",  1'b1, OP_ALU_R,  AOP_ADDC, 32'h2,        32'h3,        32'h0,        1'b0, 32'h00000005, 4'b0000);

    @(posedge clk);
    #1;
    bubble = 1'b1;
    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
    @(negedge clk);
    #1;
    if (sb.size() > 0) begin
      miscompares++;
      $display("FAIL drain: %0d checks outstanding, expected 0", sb.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
